p_fetch_stage: RTL and testbench
================================

Name: p_fetch_stage

Overview:
Instruction-fetch stage feeding the decode stage of the pipelined processor. Holds the PC, drives the instruction-memory address, and captures the fetched word plus PC+4 into the IF/ID pipeline register. Handles start-up PC load, stalls from the hazard unit, and redirects/flushes from taken branches and jumps resolved downstream.

Parameters:
START_ADDR, 32'h0000_0000, PC value loaded on reset and on load_pc
NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush or bubble (sll $0,$0,0)
CNT_W, 16, width of the issued-instruction counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
load_pc  in  1  load START_ADDR into PC and begin fetching
stall  in  1  hazard unit: hold PC and IF/ID
branch_taken  in  1  redirect from EX/MEM: take branch_target
branch_target  in  32  redirect address; bits [1:0] ignored
imem_addr  out  32  instruction memory address (= pc, combinational)
imem_data  in  32  instruction word, combinational read of imem_addr
if_id_instr  out  32  registered instruction to decode
if_id_pc4  out  32  registered PC+4 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction
fetch_count  out  CNT_W  instructions issued into IF/ID, saturating
running  out  1  FSM in RUN

Behaviour:
- Reset (reset=0, async, any time incl. mid-stall/redirect): pc=START_ADDR, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, fetch_count=0, state=IDLE, running=0. Effects of reset release appear from the first rising edge with reset=1.
- FSM states IDLE, RUN.
- IDLE: pc held, IF/ID held at NOP/invalid, stall and branch_taken ignored. load_pc=1 at edge -> pc=START_ADDR, IF/ID = NOP/invalid, -> RUN.
- RUN, per edge, priority load_pc > branch_taken > stall > normal:
  - load_pc: pc=START_ADDR; IF/ID flushed (NOP, pc4=0, valid=0); stay RUN.
  - branch_taken: pc={branch_target[31:2],2'b00}; IF/ID flushed; wins over simultaneous stall.
  - stall: pc, if_id_*, fetch_count all held.
  - normal: if_id_instr=imem_data, if_id_pc4=pc+4, if_id_valid=1, pc=pc+4, fetch_count+1.
- Latency: word at imem_addr appears on if_id_instr one edge later.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
- fetch_count saturates at all-ones; flushes and stalls do not count.
- imem_addr = pc in all states, incl. IDLE.
- No X propagation: imem_data captured only on normal fetch.

Decomposition:
- Shared package p_pkg: NOP_INSTR, instruction width 32, PC increment 4, FSM state encoding (IDLE=1'b0, RUN=1'b1). Decode stage imports the same package.
- One sub-module: p_if_id_reg (IF/ID register with hold and flush inputs, async active-low reset). PC, FSM and counter stay in the top.

Test Plan:
- Reset then load_pc pulse, no stall, imem_data = pc ^ 32'hA5A5_0000 -> after load edge pc=0; after 3 more edges if_id_instr=32'hA5A5_0008, if_id_pc4=32'h0000_000C, fetch_count=3, valid=1.
- stall held 2 cycles in RUN at pc=32'h10 -> pc, if_id_instr, fetch_count unchanged; on release next edge pc=32'h14.
- branch_taken=1 and stall=1 on same edge with branch_target=32'h0000_0103 -> pc=32'h0000_0100, if_id_instr=NOP, valid=0, fetch_count unchanged; next normal edge fetches from 32'h100.
- Force pc to 32'hFFFF_FFFC via branch, one normal edge -> pc=0, if_id_pc4=0, valid=1.
- reset asserted asynchronously mid-cycle while in RUN at pc=32'h40 -> all outputs at reset values immediately, before next edge; branch_taken ignored until load_pc.
- Saturation with CNT_W=4: 20 normal fetches -> fetch_count stays 4'hF.

Source files
------------

// File: rtl/p_pkg.sv
// Shared pipeline definitions used by the fetch and decode stages.
package p_pkg;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } if_id_t;
endpackage

// File: rtl/p_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats capture.
module p_if_id_reg
  import p_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr <= NOP;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end
endmodule

// File: rtl/p_fetch_stage.sv
// Instruction-fetch stage: PC, start-up/redirect control and IF/ID capture.
module p_fetch_stage
  import p_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = p_pkg::NOP_INSTR,
  parameter int          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_pc,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [CNT_W-1:0]   fetch_count,
  output logic               running
);
  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n, pc4;
  logic         flush, hold, fetch;
  if_id_t       if_id_d, if_id_q;

  assign pc4       = pc + PC_INC;  // wraps modulo 2^32
  assign imem_addr = pc;
  assign running   = (state == RUN);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    flush   = 1'b0;
    hold    = 1'b1;
    fetch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_pc) begin
          pc_n    = START_ADDR;
          flush   = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (load_pc) begin
          pc_n  = START_ADDR;
          flush = 1'b1;
        end else if (branch_taken) begin
          pc_n  = {branch_target[31:2], 2'b00};
          flush = 1'b1;
        end else if (!stall) begin
          pc_n  = pc4;
          hold  = 1'b0;
          fetch = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (fetch && fetch_count != '1)
        fetch_count <= fetch_count + 1'b1;
    end
  end

  // imem_data only reaches the register on a real fetch, so X on idle memory stays out
  assign if_id_d.instr = imem_data;
  assign if_id_d.pc4   = pc4;
  assign if_id_d.valid = 1'b1;

  p_if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst_n (reset),
    .hold  (hold),
    .flush (flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
endmodule

// File: tb/tb_p_fetch_stage.sv
// Directed bench for p_fetch_stage; imem model returns addr ^ 32'hA5A5_0000.
module tb_p_fetch_stage;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_pc, stall, branch_taken;
  logic [31:0]      branch_target;
  logic [31:0]      imem_addr, imem_data;
  logic [31:0]      if_id_instr, if_id_pc4;
  logic             if_id_valid, running;
  logic [CNT_W-1:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 32'hA5A5_0000;

  p_fetch_stage #(.START_ADDR(32'h0), .NOP_INSTR(32'h0), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_pc       (load_pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count),
    .running       (running)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_pc = 0; stall = 0; branch_taken = 0; branch_target = '0;
    #12;
    n_vec++;
    if (imem_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 ||
        if_id_valid !== 1'b0 || fetch_count !== 4'h0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL reset: addr=%h instr=%h pc4=%h v=%b cnt=%h run=%b", imem_addr,
               if_id_instr, if_id_pc4, if_id_valid, fetch_count, running);
    end
    #2 reset = 1'b1;
    step();
    n_vec++;
    if (running !== 1'b0 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL idle_hold: run=%b addr=%h required 0/0", running, imem_addr);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] exp_instr [3] = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008};
    logic [31:0] exp_pc4   [3] = '{32'h4, 32'h8, 32'hC};
    load_pc = 1'b1;
    step();
    load_pc = 1'b0;
    n_vec++;
    if (imem_addr !== 32'h0 || running !== 1'b1 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load: addr=%h run=%b v=%b required 0/1/0", imem_addr, running, if_id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (if_id_instr !== exp_instr[i] || if_id_pc4 !== exp_pc4[i] || if_id_valid !== 1'b1 ||
          fetch_count !== 4'(i + 1)) begin
        n_err++;
        $display("FAIL fetch%0d: instr=%h pc4=%h v=%b cnt=%0d required %h/%h/1/%0d", i,
                 if_id_instr, if_id_pc4, if_id_valid, fetch_count, exp_instr[i], exp_pc4[i], i + 1);
      end
    end
  endtask

  task automatic test_stall();
    step();  // pc 0x10, count 4
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (imem_addr !== 32'h10 || if_id_instr !== 32'hA5A5_000C || fetch_count !== 4'd4) begin
        n_err++;
        $display("FAIL stall%0d: addr=%h instr=%h cnt=%0d required 10/a5a5000c/4", i,
                 imem_addr, if_id_instr, fetch_count);
      end
    end
    stall = 1'b0;
    step();
    n_vec++;
    if (imem_addr !== 32'h14 || if_id_instr !== 32'hA5A5_0010 || fetch_count !== 4'd5) begin
      n_err++;
      $display("FAIL stall_release: addr=%h instr=%h cnt=%0d required 14/a5a50010/5",
               imem_addr, if_id_instr, fetch_count);
    end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0103;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    n_vec++;
    if (imem_addr !== 32'h100 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 ||
        if_id_valid !== 1'b0 || fetch_count !== 4'd5) begin
      n_err++;
      $display("FAIL branch_flush: addr=%h instr=%h pc4=%h v=%b cnt=%0d required 100/0/0/0/5",
               imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count);
    end
    step();
    n_vec++;
    if (if_id_instr !== 32'hA5A5_0100 || if_id_pc4 !== 32'h104 || imem_addr !== 32'h104 ||
        fetch_count !== 4'd6) begin
      n_err++;
      $display("FAIL branch_fetch: instr=%h pc4=%h addr=%h cnt=%0d required a5a50100/104/104/6",
               if_id_instr, if_id_pc4, imem_addr, fetch_count);
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    n_vec++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_redirect: addr=%h required fffffffc", imem_addr);
    end
    step();
    n_vec++;
    if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1 ||
        if_id_instr !== 32'h5A5A_FFFC || fetch_count !== 4'd7) begin
      n_err++;
      $display("FAIL wrap: addr=%h pc4=%h v=%b instr=%h cnt=%0d required 0/0/1/5a5afffc/7",
               imem_addr, if_id_pc4, if_id_valid, if_id_instr, fetch_count);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt = 7;
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_cnt < 15) exp_cnt++;
      n_vec++;
      if (fetch_count !== 4'(exp_cnt)) begin
        n_err++;
        $display("FAIL sat%0d: cnt=%0d required %0d", i, fetch_count, exp_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    n_vec++;
    if (imem_addr !== 32'h40) begin
      n_err++;
      $display("FAIL pre_reset: addr=%h required 40", imem_addr);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (imem_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 ||
        if_id_valid !== 1'b0 || fetch_count !== 4'h0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: addr=%h instr=%h pc4=%h v=%b cnt=%h run=%b", imem_addr,
               if_id_instr, if_id_pc4, if_id_valid, fetch_count, running);
    end
    #1 reset = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    n_vec++;
    if (imem_addr !== 32'h0 || running !== 1'b0 || if_id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_branch: addr=%h run=%b v=%b required 0/0/0", imem_addr, running, if_id_valid);
    end
    load_pc = 1'b1;
    step();
    load_pc = 1'b0;
    step();
    n_vec++;
    if (running !== 1'b1 || imem_addr !== 32'h4 || if_id_instr !== 32'hA5A5_0000 ||
        fetch_count !== 4'd1) begin
      n_err++;
      $display("FAIL restart: run=%b addr=%h instr=%h cnt=%0d required 1/4/a5a50000/1",
               running, imem_addr, if_id_instr, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
